axi_cdc_isolate_ctrl: RTL and testbench
=======================================

# axi_cdc_isolate_ctrl

Isolation sequencer for the source side of the AXI clock-domain crossing. It sits between the upstream master and the CDC source half on the AW/AR valid/ready pairs and monitors W/B/R handshakes. On an isolation request it stops new AW/AR, drains all outstanding bursts, and only then raises the CDC's `isolate` input, so no transaction is cut mid-flight. Release reverses the sequence.

## Interface
- `MaxTxns`, default 8: max outstanding write and read transactions, each counted separately; must be ≥ 1.
- `TimeoutCycles`, default 1024: drain timeout. Used only with `AXI_CDC_ISO_CTRL_TIMEOUT_EN`.
- Derived `CntWidth = $clog2(MaxTxns+1)`.
- `src_clk_i` in, 1: single clock. All logic is in this domain.
- `src_rst_ni` in, 1: reset. Synchronous, active-low.
- `isolate_req_i` in, 1: level request to isolate.
- `isolated_o` out, 1: isolation complete. Registered.
- `isolate_o` out, 1: drives the CDC isolate input. Registered.
- `aw_valid_i` in / `aw_ready_o` out, 1 each: upstream AW handshake.
- `aw_valid_o` out / `aw_ready_i` in, 1 each: AW handshake toward the CDC.
- `ar_valid_i`, `ar_ready_o`, `ar_valid_o`, `ar_ready_i`: same scheme for AR.
- `w_valid_i`, `w_ready_i`, `w_last_i` in, 1 each: monitored only.
- `b_valid_i`, `b_ready_i` in, 1 each: monitored only.
- `r_valid_i`, `r_ready_i`, `r_last_i` in, 1 each: monitored only.
- `timeout_o` out, 1: sticky drain-timeout flag. Tied to 0 when the macro is absent.

## Operation
- States: `RUN`, `DRAIN`, `ISOLATED`. Reset state is `RUN`.
- Gating:
  - `aw_valid_o = aw_valid_i & aw_open`, `aw_ready_o = aw_ready_i & aw_open`.
  - `aw_open` = (state==`RUN`) & (wr_cnt != MaxTxns).
  - AR is gated the same way using rd_cnt.
- Counters, each up/down, with increment and decrement in the same cycle leaving the value unchanged:
  - wr_cnt: +1 on AW handshake at the CDC side, −1 on B handshake.
  - rd_cnt: +1 on AR handshake, −1 on R handshake with `r_last_i`.
  - w_bal: signed, CntWidth+1 bits. +1 on AW handshake, −1 on W handshake with last. Negative values (W ahead of AW) are legal.
  - w_open: set on a W handshake without last, cleared on a W handshake with last.
- An underflow of wr_cnt or rd_cnt is a protocol error. It is asserted in simulation; the counter holds at 0.
- `drained` = wr_cnt==0 & rd_cnt==0 & w_bal==0 & !w_open.
- Transitions:
  - `RUN`→`DRAIN` when `isolate_req_i`=1.
  - `DRAIN`→`ISOLATED` when `drained`.
  - `DRAIN`→`RUN` when `isolate_req_i`=0; release has priority over `drained` in the same cycle.
  - `ISOLATED`→`RUN` when `isolate_req_i`=0.
- W, B and R are never gated by this block; draining relies on them flowing.

## Timing
- State, counters and outputs are registered. Gating is derived from the registered state.
- An AW/AR handshake in the same cycle as the `isolate_req_i` rise is accepted and counted.
- Request to isolation, already drained: `isolate_req_i` high at edge N, `DRAIN` at N+1, `isolate_o`=`isolated_o`=1 at N+2.
- Release: `isolate_req_i` low at edge M, `RUN` with both outputs 0 at M+1. AW/AR reopen at M+1.
- Reset values: state `RUN`, all counters 0, w_open 0, `isolate_o` 0, `isolated_o` 0, `timeout_o` 0.
- Reset mid-drain discards all tracking. Integration resets the CDC together with this block.
- Counter saturation: at wr_cnt==MaxTxns, AW stalls (valid and ready both low) until a B is accepted. The same applies to AR.

## Configuration
- `AXI_CDC_ISO_CTRL_TIMEOUT_EN` defined:
  - A drain timer clears on entry to `DRAIN` and counts while in `DRAIN`.
  - When it reaches `TimeoutCycles`, the block forces `ISOLATED` and sets `timeout_o`.
  - `timeout_o` stays set until reset.
- Macro absent: no timer, `DRAIN` waits indefinitely, `timeout_o`=0.

## Structure
- Package `axi_cdc_iso_pkg`: state enum `iso_state_e` {`RUN`, `DRAIN`, `ISOLATED`} and the `CntWidth` function.
- Sub-module `axi_cdc_txn_counter`:
  - Inputs: inc, dec, synchronous clear.
  - Outputs: count, `full`, `empty`.
  - Instanced for wr_cnt and rd_cnt. w_bal is a signed variant selected by a parameter.

## Test plan
- Idle isolate: no traffic, raise req → `isolate_o`=1 two edges later, `aw_ready_o`=0 from the first edge.
- Write drain: 3 AWs accepted, req raised, Ws and Bs delayed 20 cycles → `isolate_o` stays 0 until the 3rd B and the final W last, then 1 on the next edge; a new `aw_valid_i` during `DRAIN` is never accepted.
- W-first: W burst of 4 beats completes before its AW, then the AW, then the B, with req high → isolates only after the B; w_bal passes through −1 and returns to 0.
- Saturation: MaxTxns=8, 8 ARs with no R → 9th AR stalls; one R last → 9th AR is accepted on the next cycle.
- Abort: req raised with 2 reads pending, dropped after 5 cycles → back in `RUN`, `isolate_o` never 1.
- Timeout (macro on, TimeoutCycles=16): 1 write that never completes, req raised → `isolate_o`=1 and `timeout_o`=1 after 16 `DRAIN` cycles.

Source files
------------

// File: rtl/axi_cdc_isolate_ctrl_pkg.sv
// Shared types for the AXI CDC isolation sequencer: FSM state encoding,
// channel indices for the per-channel transaction counters, and the
// counter width helper.
package axi_cdc_iso_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        ISOLATED = 2'd2
    } iso_state_e;

    // Outstanding-transaction counters are kept as a small channel array.
    localparam int unsigned NumCh = 2;
    localparam int unsigned ChWr  = 0;
    localparam int unsigned ChRd  = 1;

    // Bits needed to hold 0..max_txns inclusive (the CntWidth value).
    function automatic int unsigned cnt_width(input int unsigned max_txns);
        return $clog2(max_txns + 1);
    endfunction

endpackage

// File: rtl/axi_cdc_isolate_ctrl_if.sv
// Handshake bundle between the upstream master, the isolation sequencer and
// the CDC source half. The sequencer uses the slave view; whatever drives the
// upstream/CDC side (or a bench) uses the master view.
interface axi_cdc_isolate_ctrl_if;

    logic isolate_req_i;
    logic isolated_o;
    logic isolate_o;
    logic timeout_o;

    logic aw_valid_i;
    logic aw_ready_o;
    logic aw_valid_o;
    logic aw_ready_i;

    logic ar_valid_i;
    logic ar_ready_o;
    logic ar_valid_o;
    logic ar_ready_i;

    logic w_valid_i;
    logic w_ready_i;
    logic w_last_i;
    logic b_valid_i;
    logic b_ready_i;
    logic r_valid_i;
    logic r_ready_i;
    logic r_last_i;

    modport master (
        output isolate_req_i,
        output aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i,
        output w_valid_i, w_ready_i, w_last_i,
        output b_valid_i, b_ready_i,
        output r_valid_i, r_ready_i, r_last_i,
        input  isolated_o, isolate_o, timeout_o,
        input  aw_ready_o, aw_valid_o, ar_ready_o, ar_valid_o
    );

    modport slave (
        input  isolate_req_i,
        input  aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i,
        input  w_valid_i, w_ready_i, w_last_i,
        input  b_valid_i, b_ready_i,
        input  r_valid_i, r_ready_i, r_last_i,
        output isolated_o, isolate_o, timeout_o,
        output aw_ready_o, aw_valid_o, ar_ready_o, ar_valid_o
    );

endinterface

// File: rtl/axi_cdc_txn_counter.sv
// Up/down transaction counter. Unsigned flavour tracks outstanding AW/AR
// bursts and holds at zero on an unmatched decrement (a protocol error that
// is flagged in simulation). Signed flavour tracks the AW-vs-W-last balance,
// where negative values mean W data ran ahead of its address.
module axi_cdc_txn_counter #(
    parameter int unsigned Width    = 4,
    parameter int unsigned MaxVal   = 8,
    parameter bit          IsSigned = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [Width-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [Width-1:0] cnt_q;
    logic             underflow;

    assign underflow = !IsSigned && dec && !inc && (cnt_q == '0);

    // Count up/down; a simultaneous inc and dec cancel, an underflow holds.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt_q <= '0;
        end else if (inc && !dec) begin
            cnt_q <= cnt_q + Width'(1);
        end else if (dec && !inc && !underflow) begin
            cnt_q <= cnt_q - Width'(1);
        end
    end

    assign count = cnt_q;
    assign full  = (cnt_q == Width'(MaxVal));
    assign empty = (cnt_q == '0);

    // A response with nothing outstanding means the upstream protocol broke.
    assert property (@(posedge clk) disable iff (!rst_n) !underflow);

endmodule

// File: rtl/axi_cdc_isolate_ctrl.sv
// Isolation sequencer for the source side of the AXI CDC. On an isolation
// request it closes AW/AR, waits for every outstanding write/read (and any
// stray W data) to finish, then raises isolate_o. Dropping the request
// returns straight to RUN.
// Optional feature macro: AXI_CDC_ISO_CTRL_TIMEOUT_EN adds a drain timer that
// forces isolation after TimeoutCycles in DRAIN and latches timeout_o.
module axi_cdc_isolate_ctrl
    import axi_cdc_iso_pkg::*;
#(
    parameter int unsigned MaxTxns       = 8,
    parameter int unsigned TimeoutCycles = 1024
) (
    input logic                   src_clk_i,
    input logic                   src_rst_ni,
    axi_cdc_isolate_ctrl_if.slave bus
);

    localparam int unsigned CntWidth = cnt_width(MaxTxns);

    iso_state_e                          state_q;
    logic                                iso_q;
    logic                                w_open_q;
    logic [NumCh-1:0]                    ch_open, ch_inc, ch_dec, ch_full, ch_empty;
    logic [NumCh-1:0][CntWidth-1:0]      ch_cnt;
    logic [CntWidth:0]                   w_bal;
    logic                                w_full, w_empty;
    logic                                aw_hs, ar_hs, w_hs, b_hs, r_hs;
    logic                                drained, tmr_hit;

    // Gating comes from registered state only, so the request edge itself
    // never cuts an AW/AR that is already being handshaken.
    for (genvar c = 0; c < NumCh; c++) begin : g_open
        assign ch_open[c] = (state_q == RUN) && !ch_full[c];
    end

    assign bus.aw_valid_o = bus.aw_valid_i & ch_open[ChWr];
    assign bus.aw_ready_o = bus.aw_ready_i & ch_open[ChWr];
    assign bus.ar_valid_o = bus.ar_valid_i & ch_open[ChRd];
    assign bus.ar_ready_o = bus.ar_ready_i & ch_open[ChRd];

    assign aw_hs = bus.aw_valid_i & bus.aw_ready_i & ch_open[ChWr];
    assign ar_hs = bus.ar_valid_i & bus.ar_ready_i & ch_open[ChRd];
    assign w_hs  = bus.w_valid_i & bus.w_ready_i;
    assign b_hs  = bus.b_valid_i & bus.b_ready_i;
    assign r_hs  = bus.r_valid_i & bus.r_ready_i;

    assign ch_inc[ChWr] = aw_hs;
    assign ch_dec[ChWr] = b_hs;
    assign ch_inc[ChRd] = ar_hs;
    assign ch_dec[ChRd] = r_hs & bus.r_last_i;

    for (genvar c = 0; c < NumCh; c++) begin : g_cnt
        axi_cdc_txn_counter #(
            .Width   (CntWidth),
            .MaxVal  (MaxTxns),
            .IsSigned(1'b0)
        ) u_cnt (
            .clk  (src_clk_i),
            .rst_n(src_rst_ni),
            .clr  (1'b0),
            .inc  (ch_inc[c]),
            .dec  (ch_dec[c]),
            .count(ch_cnt[c]),
            .full (ch_full[c]),
            .empty(ch_empty[c])
        );

        assert property (@(posedge src_clk_i) disable iff (!src_rst_ni)
            ch_cnt[c] <= CntWidth'(MaxTxns));
    end

    // AW-vs-W-last balance; one extra bit so W may lead AW.
    axi_cdc_txn_counter #(
        .Width   (CntWidth + 1),
        .MaxVal  (MaxTxns),
        .IsSigned(1'b1)
    ) u_w_bal (
        .clk  (src_clk_i),
        .rst_n(src_rst_ni),
        .clr  (1'b0),
        .inc  (aw_hs),
        .dec  (w_hs & bus.w_last_i),
        .count(w_bal),
        .full (w_full),
        .empty(w_empty)
    );

    // W data can never lag by more addresses than may be outstanding.
    assert property (@(posedge src_clk_i) disable iff (!src_rst_ni)
        $signed(w_bal) <= $signed({1'b0, CntWidth'(MaxTxns)}));
    assert property (@(posedge src_clk_i) disable iff (!src_rst_ni) w_full |-> !aw_hs);
    assert property (@(posedge src_clk_i) MaxTxns >= 1 && TimeoutCycles >= 1);

    // Track a W burst that has started but not yet delivered its last beat.
    always_ff @(posedge src_clk_i) begin
        if (!src_rst_ni) begin
            w_open_q <= 1'b0;
        end else if (w_hs) begin
            w_open_q <= !bus.w_last_i;
        end
    end

    assign drained = (&ch_empty) && w_empty && !w_open_q;

`ifdef AXI_CDC_ISO_CTRL_TIMEOUT_EN
    localparam int unsigned TmrWidth = $clog2(TimeoutCycles + 1);

    logic [TmrWidth-1:0] tmr_q;
    logic                tmo_q;

    // Hit one early so exactly TimeoutCycles cycles are spent in DRAIN.
    assign tmr_hit = (tmr_q == TmrWidth'(TimeoutCycles - 1));

    // Drain timer: held at zero outside DRAIN so every entry starts fresh.
    always_ff @(posedge src_clk_i) begin
        if (!src_rst_ni || state_q != DRAIN) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_q + TmrWidth'(1);
        end
    end

    // Sticky flag, set only when the timer rather than the drain ends DRAIN.
    always_ff @(posedge src_clk_i) begin
        if (!src_rst_ni) begin
            tmo_q <= 1'b0;
        end else if (state_q == DRAIN && bus.isolate_req_i && !drained && tmr_hit) begin
            tmo_q <= 1'b1;
        end
    end

    assign bus.timeout_o = tmo_q;
`else
    assign tmr_hit       = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    // Sequencer: release beats drain/timeout; isolation output moves with state.
    always_ff @(posedge src_clk_i) begin
        if (!src_rst_ni) begin
            state_q <= RUN;
            iso_q   <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.isolate_req_i) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!bus.isolate_req_i) begin
                        state_q <= RUN;
                    end else if (drained || tmr_hit) begin
                        state_q <= ISOLATED;
                        iso_q   <= 1'b1;
                    end
                end
                ISOLATED: begin
                    if (!bus.isolate_req_i) begin
                        state_q <= RUN;
                        iso_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= RUN;
                    iso_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.isolate_o  = iso_q;
    assign bus.isolated_o = iso_q;

endmodule

// File: tb/tb_axi_cdc_isolate_ctrl.sv
// Directed bench for axi_cdc_isolate_ctrl. Stimulus pushes the cycle at
// which each AW/AR handshake and each isolate/timeout output change must be
// seen; a negedge monitor pops and compares as the DUT produces them.
// Build with AXI_CDC_ISO_CTRL_TIMEOUT_EN defined to also run the timeout case.
module tb_axi_cdc_isolate_ctrl;

    localparam int K_AW  = 0;
    localparam int K_AR  = 1;
    localparam int K_ISO = 2;
    localparam int K_TMO = 3;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    int unsigned cyc    = 0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  val;
    } exp_t;

    exp_t q_aw[$];
    exp_t q_ar[$];
    exp_t q_iso[$];
    exp_t q_tmo[$];

    axi_cdc_isolate_ctrl_if bus_if ();

    axi_cdc_isolate_ctrl #(
        .MaxTxns      (8),
        .TimeoutCycles(16)
    ) dut (
        .src_clk_i (clk),
        .src_rst_ni(rst_n),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int k, input int unsigned c, input logic [1:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        case (k)
            K_AW:    q_aw.push_back(e);
            K_AR:    q_ar.push_back(e);
            K_ISO:   q_iso.push_back(e);
            default: q_tmo.push_back(e);
        endcase
    endtask

    task automatic score(input int k, input logic [1:0] val);
        exp_t  e;
        bit    have;
        string nm;
        have = 1'b0;
        e.cyc = 0;
        e.val = 2'b00;
        case (k)
            K_AW: begin
                nm = "aw_handshake";
                if (q_aw.size() > 0) begin e = q_aw.pop_front(); have = 1'b1; end
            end
            K_AR: begin
                nm = "ar_handshake";
                if (q_ar.size() > 0) begin e = q_ar.pop_front(); have = 1'b1; end
            end
            K_ISO: begin
                nm = "isolate_change";
                if (q_iso.size() > 0) begin e = q_iso.pop_front(); have = 1'b1; end
            end
            default: begin
                nm = "timeout_change";
                if (q_tmo.size() > 0) begin e = q_tmo.pop_front(); have = 1'b1; end
            end
        endcase
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL %s: unexpected event at cycle %0d val %0b, none required", nm, cyc, val);
        end else if (e.cyc != cyc || e.val !== val) begin
            errors++;
            $display("FAIL %s: got cycle %0d val %0b, want cycle %0d val %0b", nm, cyc, val, e.cyc, e.val);
        end
    endtask

    // Monitor: every CDC-side handshake and every output change is scored.
    logic [1:0] iso_prev = 2'b00;
    logic       tmo_prev = 1'b0;
    always @(negedge clk) begin
        if (bus_if.aw_valid_o && bus_if.aw_ready_i) score(K_AW, 2'b01);
        if (bus_if.ar_valid_o && bus_if.ar_ready_i) score(K_AR, 2'b01);
        if ({bus_if.isolate_o, bus_if.isolated_o} !== iso_prev) begin
            score(K_ISO, {bus_if.isolate_o, bus_if.isolated_o});
            iso_prev = {bus_if.isolate_o, bus_if.isolated_o};
        end
        if (bus_if.timeout_o !== tmo_prev) begin
            score(K_TMO, {1'b0, bus_if.timeout_o});
            tmo_prev = bus_if.timeout_o;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus_if.isolate_req_i = 1'b0;
        bus_if.aw_valid_i = 1'b0; bus_if.aw_ready_i = 1'b1;
        bus_if.ar_valid_i = 1'b0; bus_if.ar_ready_i = 1'b1;
        bus_if.w_valid_i = 1'b0;  bus_if.w_ready_i = 1'b1; bus_if.w_last_i = 1'b0;
        bus_if.b_valid_i = 1'b0;  bus_if.b_ready_i = 1'b1;
        bus_if.r_valid_i = 1'b0;  bus_if.r_ready_i = 1'b1; bus_if.r_last_i = 1'b0;

        // Reset state
        tick(3);
        check("reset_isolate_o", bus_if.isolate_o, 0);
        check("reset_isolated_o", bus_if.isolated_o, 0);
        check("reset_timeout_o", bus_if.timeout_o, 0);
        check("reset_aw_ready_open", bus_if.aw_ready_o, 1);
        rst_n = 1'b1;
        tick();

        // Idle isolate and release
        bus_if.isolate_req_i = 1'b1;
        expect_ev(K_ISO, cyc + 2, 2'b11);
        tick();
        check("idle_aw_ready_closed", bus_if.aw_ready_o, 0);
        check("idle_ar_ready_closed", bus_if.ar_ready_o, 0);
        tick(3);
        bus_if.isolate_req_i = 1'b0;
        expect_ev(K_ISO, cyc + 1, 2'b00);
        tick();
        check("release_aw_ready_open", bus_if.aw_ready_o, 1);
        tick();

        // Write drain: third AW coincides with the request edge
        bus_if.aw_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus_if.isolate_req_i = 1'b1;
            expect_ev(K_AW, cyc, 2'b01);
            tick();
        end
        check("drain_aw_valid_gated", bus_if.aw_valid_o, 0);
        check("drain_aw_ready_gated", bus_if.aw_ready_o, 0);
        tick(20);
        bus_if.w_valid_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus_if.w_last_i = (i % 2 == 1);
            tick();
        end
        bus_if.w_valid_i = 1'b0;
        bus_if.w_last_i = 1'b0;
        bus_if.b_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) expect_ev(K_ISO, cyc + 2, 2'b11);
            tick();
        end
        bus_if.b_valid_i = 1'b0;
        tick(3);
        // Release with AW still pending: reopens on the release edge
        bus_if.isolate_req_i = 1'b0;
        expect_ev(K_ISO, cyc + 1, 2'b00);
        expect_ev(K_AW, cyc + 1, 2'b01);
        tick();
        tick();
        bus_if.aw_valid_i = 1'b0;
        bus_if.w_valid_i = 1'b1; bus_if.w_last_i = 1'b1;
        tick();
        bus_if.w_valid_i = 1'b0; bus_if.w_last_i = 1'b0;
        bus_if.b_valid_i = 1'b1;
        tick();
        bus_if.b_valid_i = 1'b0;
        tick();

        // W-first: 4-beat burst before its AW, isolation waits for the B
        bus_if.w_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_if.w_last_i = (i == 3);
            tick();
        end
        bus_if.w_valid_i = 1'b0;
        bus_if.w_last_i = 1'b0;
        bus_if.aw_valid_i = 1'b1;
        bus_if.isolate_req_i = 1'b1;
        expect_ev(K_AW, cyc, 2'b01);
        tick();
        bus_if.aw_valid_i = 1'b0;
        tick(5);
        bus_if.b_valid_i = 1'b1;
        expect_ev(K_ISO, cyc + 2, 2'b11);
        tick();
        bus_if.b_valid_i = 1'b0;
        tick(3);
        bus_if.isolate_req_i = 1'b0;
        expect_ev(K_ISO, cyc + 1, 2'b00);
        tick(2);

        // AR saturation at MaxTxns
        bus_if.ar_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_ev(K_AR, cyc, 2'b01);
            tick();
        end
        check("sat_ar_valid_stall", bus_if.ar_valid_o, 0);
        check("sat_ar_ready_stall", bus_if.ar_ready_o, 0);
        check("sat_aw_unaffected", bus_if.aw_ready_o, 1);
        tick(3);
        bus_if.r_valid_i = 1'b1; bus_if.r_last_i = 1'b1;
        expect_ev(K_AR, cyc + 1, 2'b01);
        tick();
        bus_if.r_valid_i = 1'b0; bus_if.r_last_i = 1'b0;
        check("sat_ar_reopen", bus_if.ar_ready_o, 1);
        tick();
        bus_if.ar_valid_i = 1'b0;
        check("sat_ar_full_again", bus_if.ar_ready_o, 0);
        bus_if.r_valid_i = 1'b1; bus_if.r_last_i = 1'b1;
        tick(8);
        bus_if.r_valid_i = 1'b0; bus_if.r_last_i = 1'b0;
        tick();

        // Abort: request dropped with reads outstanding
        bus_if.ar_valid_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            expect_ev(K_AR, cyc, 2'b01);
            tick();
        end
        bus_if.ar_valid_i = 1'b0;
        bus_if.isolate_req_i = 1'b1;
        tick();
        check("abort_ar_closed", bus_if.ar_ready_o, 0);
        tick(4);
        bus_if.isolate_req_i = 1'b0;
        tick();
        check("abort_ar_reopen", bus_if.ar_ready_o, 1);
        check("abort_aw_reopen", bus_if.aw_ready_o, 1);
        check("abort_isolate_low", bus_if.isolate_o, 0);
        // Two 2-beat read bursts; only the last beats retire a read
        bus_if.r_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_if.r_last_i = (i % 2 == 1);
            tick();
        end
        bus_if.r_valid_i = 1'b0; bus_if.r_last_i = 1'b0;
        tick();
        bus_if.isolate_req_i = 1'b1;
        expect_ev(K_ISO, cyc + 2, 2'b11);
        tick(3);
        bus_if.isolate_req_i = 1'b0;
        expect_ev(K_ISO, cyc + 1, 2'b00);
        tick(2);

`ifdef AXI_CDC_ISO_CTRL_TIMEOUT_EN
        // Timeout: one write that never completes
        bus_if.aw_valid_i = 1'b1;
        expect_ev(K_AW, cyc, 2'b01);
        tick();
        bus_if.aw_valid_i = 1'b0;
        bus_if.isolate_req_i = 1'b1;
        expect_ev(K_ISO, cyc + 17, 2'b11);
        expect_ev(K_TMO, cyc + 17, 2'b01);
        tick(20);
        check("timeout_set", bus_if.timeout_o, 1);
        bus_if.isolate_req_i = 1'b0;
        expect_ev(K_ISO, cyc + 1, 2'b00);
        tick(3);
        check("timeout_sticky", bus_if.timeout_o, 1);
`endif

        // Reset mid-drain discards tracking
        bus_if.aw_valid_i = 1'b1;
        expect_ev(K_AW, cyc, 2'b01);
        tick();
        bus_if.aw_valid_i = 1'b0;
        bus_if.isolate_req_i = 1'b1;
        tick(3);
        check("middrain_isolate_low", bus_if.isolate_o, 0);
        rst_n = 1'b0;
        bus_if.isolate_req_i = 1'b0;
`ifdef AXI_CDC_ISO_CTRL_TIMEOUT_EN
        expect_ev(K_TMO, cyc + 1, 2'b00);
`endif
        tick(2);
        check("postreset_timeout_o", bus_if.timeout_o, 0);
        rst_n = 1'b1;
        tick();
        bus_if.isolate_req_i = 1'b1;
        expect_ev(K_ISO, cyc + 2, 2'b11);
        tick(3);
        bus_if.isolate_req_i = 1'b0;
        expect_ev(K_ISO, cyc + 1, 2'b00);
        tick(3);

        // Every required event must have been seen
        check("missing_aw_events", q_aw.size(), 0);
        check("missing_ar_events", q_ar.size(), 0);
        check("missing_iso_events", q_iso.size(), 0);
        check("missing_tmo_events", q_tmo.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
